// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with EX-side operand forwarding, ALU op decode
// and load-use hazard detection for the 5-stage MIPS pipeline.
module ex_operand_stage #(
    parameter int unsigned DW = 32,
    parameter int unsigned RW = 5
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          stall,
    input  logic          flush,
    input  logic          id_valid,
    input  logic [DW-1:0] id_rs_data,
    input  logic [DW-1:0] id_rt_data,
    input  logic [DW-1:0] id_imm,
    input  logic [RW-1:0] id_rs,
    input  logic [RW-1:0] id_rt,
    input  logic [RW-1:0] id_rd,
    input  logic [1:0]    id_aluop,
    input  logic [5:0]    id_funct,
    input  logic          id_alusrc,
    input  logic          id_regdst,
    input  logic          id_regwrite,
    input  logic          id_memread,
    input  logic          id_memwrite,
    input  logic          id_memtoreg,
    input  logic          exmem_regwrite,
    input  logic [RW-1:0] exmem_rd,
    input  logic [DW-1:0] exmem_result,
    input  logic          memwb_regwrite,
    input  logic [RW-1:0] memwb_rd,
    input  logic [DW-1:0] memwb_result,
    output logic [DW-1:0] alu_a,
    output logic [DW-1:0] alu_b,
    output logic [3:0]    alu_op,
    output logic [DW-1:0] ex_store_data,
    output logic [RW-1:0] ex_dst,
    output logic          ex_valid,
    output logic          ex_regwrite,
    output logic          ex_memread,
    output logic          ex_memwrite,
    output logic          ex_memtoreg,
    output logic          load_use_hazard
);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;

    typedef struct packed {
        logic          valid;
        logic          alusrc;
        logic          regdst;
        logic          regwrite;
        logic          memread;
        logic          memwrite;
        logic          memtoreg;
        logic [1:0]    aluop;
        logic [5:0]    funct;
        logic [RW-1:0] rs;
        logic [RW-1:0] rt;
        logic [RW-1:0] rd;
        logic [DW-1:0] rs_data;
        logic [DW-1:0] rt_data;
        logic [DW-1:0] imm;
    } idex_t;

    idex_t idex_q;
    idex_t id_cap;
    logic [DW-1:0] fwd_rs;
    logic [DW-1:0] fwd_rt;

    // ID-side capture; control bits are qualified by id_valid so bubbles stay inert
    always_comb begin
        id_cap          = '0;
        id_cap.valid    = id_valid;
        id_cap.alusrc   = id_alusrc;
        id_cap.regdst   = id_regdst;
        id_cap.regwrite = id_regwrite & id_valid;
        id_cap.memread  = id_memread  & id_valid;
        id_cap.memwrite = id_memwrite & id_valid;
        id_cap.memtoreg = id_memtoreg & id_valid;
        id_cap.aluop    = id_aluop;
        id_cap.funct    = id_funct;
        id_cap.rs       = id_rs;
        id_cap.rt       = id_rt;
        id_cap.rd       = id_rd;
        id_cap.rs_data  = id_rs_data;
        id_cap.rt_data  = id_rt_data;
        id_cap.imm      = id_imm;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idex_q <= '0;
        end else if (flush) begin
            idex_q <= '0;
        end else if (!stall) begin
            idex_q <= id_cap;
        end
    end

    // Forwarding: later assignment wins, so EX/MEM overrides MEM/WB
    always_comb begin
        fwd_rs = idex_q.rs_data;
        if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_q.rs)) fwd_rs = memwb_result;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_q.rs)) fwd_rs = exmem_result;
    end

    always_comb begin
        fwd_rt = idex_q.rt_data;
        if (memwb_regwrite && (memwb_rd != '0) && (memwb_rd == idex_q.rt)) fwd_rt = memwb_result;
        if (exmem_regwrite && (exmem_rd != '0) && (exmem_rd == idex_q.rt)) fwd_rt = exmem_result;
    end

    always_comb begin
        alu_op = OP_ADD;
        case (idex_q.aluop)
            2'b00: alu_op = OP_ADD;
            2'b01: alu_op = OP_SUB;
            2'b11: alu_op = OP_OR;
            default: begin
                case (idex_q.funct)
                    6'b100000, 6'b100001: alu_op = OP_ADD;
                    6'b100010, 6'b100011: alu_op = OP_SUB;
                    6'b100100:            alu_op = OP_AND;
                    6'b100101:            alu_op = OP_OR;
                    6'b101010:            alu_op = OP_SLT;
                    default:              alu_op = OP_ADD;
                endcase
            end
        endcase
    end

    assign alu_a         = fwd_rs;
    assign alu_b         = idex_q.alusrc ? idex_q.imm : fwd_rt;
    assign ex_store_data = fwd_rt;
    assign ex_dst        = idex_q.regdst ? idex_q.rd : idex_q.rt;
    assign ex_valid      = idex_q.valid;
    assign ex_regwrite   = idex_q.regwrite;
    assign ex_memread    = idex_q.memread;
    assign ex_memwrite   = idex_q.memwrite;
    assign ex_memtoreg   = idex_q.memtoreg;

    // A load in EX writes its rt; any ID source reading that register must wait
    assign load_use_hazard = idex_q.valid & idex_q.memread & (idex_q.rt != '0) &
                             ((idex_q.rt == id_rs) | (idex_q.rt == id_rt)) & id_valid;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus randomized
// traffic compared against a behavioural model of the ID/EX stage.
module tb_ex_operand_stage;

    localparam int unsigned DW = 32;
    localparam int unsigned RW = 5;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          stall, flush, id_valid;
    logic [DW-1:0] id_rs_data, id_rt_data, id_imm;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic [1:0]    id_aluop;
    logic [5:0]    id_funct;
    logic          id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg;
    logic          exmem_regwrite, memwb_regwrite;
    logic [RW-1:0] exmem_rd, memwb_rd;
    logic [DW-1:0] exmem_result, memwb_result;
    logic [DW-1:0] alu_a, alu_b, ex_store_data;
    logic [3:0]    alu_op;
    logic [RW-1:0] ex_dst;
    logic          ex_valid, ex_regwrite, ex_memread, ex_memwrite, ex_memtoreg, load_use_hazard;

    int n_checks = 0;
    int n_fail   = 0;

    // Model of the instruction currently held in EX
    logic          m_valid, m_alusrc, m_regdst, m_regwrite, m_memread, m_memwrite, m_memtoreg;
    logic [1:0]    m_aluop;
    logic [5:0]    m_funct;
    logic [RW-1:0] m_rs, m_rt, m_rd;
    logic [DW-1:0] m_rs_data, m_rt_data, m_imm;

    always #5 clk = ~clk;

    ex_operand_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .id_valid(id_valid),
        .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_aluop(id_aluop), .id_funct(id_funct),
        .id_alusrc(id_alusrc), .id_regdst(id_regdst), .id_regwrite(id_regwrite),
        .id_memread(id_memread), .id_memwrite(id_memwrite), .id_memtoreg(id_memtoreg),
        .exmem_regwrite(exmem_regwrite), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
        .memwb_regwrite(memwb_regwrite), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
        .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .ex_store_data(ex_store_data),
        .ex_dst(ex_dst), .ex_valid(ex_valid), .ex_regwrite(ex_regwrite),
        .ex_memread(ex_memread), .ex_memwrite(ex_memwrite), .ex_memtoreg(ex_memtoreg),
        .load_use_hazard(load_use_hazard)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [3:0] ref_op(input logic [1:0] aluop, input logic [5:0] funct);
        if (aluop == 2'd0) return 4'd2;
        if (aluop == 2'd1) return 4'd6;
        if (aluop == 2'd3) return 4'd1;
        if (funct == 6'h20 || funct == 6'h21) return 4'd2;
        if (funct == 6'h22 || funct == 6'h23) return 4'd6;
        if (funct == 6'h24) return 4'd0;
        if (funct == 6'h25) return 4'd1;
        if (funct == 6'h2a) return 4'd7;
        return 4'd2;
    endfunction

    function automatic logic [DW-1:0] ref_fwd(input logic [RW-1:0] idx, input logic [DW-1:0] regval);
        if (idx == 0) return regval;
        if (exmem_regwrite && exmem_rd == idx) return exmem_result;
        if (memwb_regwrite && memwb_rd == idx) return memwb_result;
        return regval;
    endfunction

    task automatic model_reset();
        {m_valid, m_alusrc, m_regdst, m_regwrite, m_memread, m_memwrite, m_memtoreg} = '0;
        m_aluop = '0; m_funct = '0; m_rs = '0; m_rt = '0; m_rd = '0;
        m_rs_data = '0; m_rt_data = '0; m_imm = '0;
    endtask

    task automatic model_clk();
        if (flush) begin
            model_reset();
        end else if (!stall) begin
            m_valid = id_valid; m_alusrc = id_alusrc; m_regdst = id_regdst;
            m_regwrite = id_regwrite && id_valid; m_memread = id_memread && id_valid;
            m_memwrite = id_memwrite && id_valid; m_memtoreg = id_memtoreg && id_valid;
            m_aluop = id_aluop; m_funct = id_funct; m_rs = id_rs; m_rt = id_rt; m_rd = id_rd;
            m_rs_data = id_rs_data; m_rt_data = id_rt_data; m_imm = id_imm;
        end
    endtask

    task automatic check_all();
        logic [DW-1:0] rtf;
        rtf = ref_fwd(m_rt, m_rt_data);
        check("alu_a", 64'(alu_a), 64'(ref_fwd(m_rs, m_rs_data)));
        check("alu_b", 64'(alu_b), 64'(m_alusrc ? m_imm : rtf));
        check("store", 64'(ex_store_data), 64'(rtf));
        check("alu_op", 64'(alu_op), 64'(ref_op(m_aluop, m_funct)));
        check("ex_dst", 64'(ex_dst), 64'(m_regdst ? m_rd : m_rt));
        check("ex_valid", 64'(ex_valid), 64'(m_valid));
        check("ex_regwrite", 64'(ex_regwrite), 64'(m_regwrite));
        check("ex_memread", 64'(ex_memread), 64'(m_memread));
        check("ex_memwrite", 64'(ex_memwrite), 64'(m_memwrite));
        check("ex_memtoreg", 64'(ex_memtoreg), 64'(m_memtoreg));
        check("hazard", 64'(load_use_hazard),
              64'(m_valid && m_memread && m_rt != 0 && (m_rt == id_rs || m_rt == id_rt) && id_valid));
    endtask

    task automatic tick();
        @(posedge clk);
        model_clk();
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
        check_all();
    endtask

    task automatic rand_id();
        id_valid = ($urandom_range(0, 3) != 0);
        id_rs = RW'($urandom_range(0, 7)); id_rt = RW'($urandom_range(0, 7));
        id_rd = RW'($urandom_range(0, 7));
        id_rs_data = $urandom; id_rt_data = $urandom; id_imm = $urandom;
        id_aluop = 2'($urandom); id_funct = ($urandom_range(0, 1) != 0) ? 6'($urandom_range(32, 43)) : 6'($urandom);
        {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = 6'($urandom);
    endtask

    task automatic rand_fwd();
        exmem_regwrite = 1'($urandom); memwb_regwrite = 1'($urandom);
        exmem_rd = RW'($urandom_range(0, 7)); memwb_rd = RW'($urandom_range(0, 7));
        exmem_result = $urandom; memwb_result = $urandom;
    endtask

    task automatic clear_id();
        id_valid = 1'b1; id_rs = '0; id_rt = '0; id_rd = '0;
        id_rs_data = '0; id_rt_data = '0; id_imm = '0; id_aluop = 2'b00; id_funct = '0;
        {id_alusrc, id_regdst, id_regwrite, id_memread, id_memwrite, id_memtoreg} = '0;
        exmem_regwrite = 1'b0; memwb_regwrite = 1'b0; exmem_rd = '0; memwb_rd = '0;
        exmem_result = '0; memwb_result = '0;
    endtask

    logic [5:0] functs [5] = '{6'h22, 6'h24, 6'h25, 6'h2a, 6'h3f};
    logic [3:0] fops   [5] = '{4'd6, 4'd0, 4'd1, 4'd7, 4'd2};

    initial begin
        logic [DW-1:0] held_a, held_b;
        logic [RW-1:0] held_dst;

        // Reset with random ID inputs present
        rst_n = 1'b0; stall = 1'b0; flush = 1'b0;
        rand_id(); rand_fwd(); exmem_regwrite = 1'b0; memwb_regwrite = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_valid", 64'(ex_valid), 64'd0);
        check("rst_regwrite", 64'(ex_regwrite), 64'd0);
        check("rst_op", 64'(alu_op), 64'd2);
        check("rst_a", 64'(alu_a), 64'd0);
        check("rst_b", 64'(alu_b), 64'd0);
        check_all();
        rst_n = 1'b1;

        // add $3,$1,$2
        clear_id();
        id_rs = 5'd1; id_rt = 5'd2; id_rd = 5'd3; id_rs_data = 32'd5; id_rt_data = 32'd7;
        id_aluop = 2'b10; id_funct = 6'h20; id_regdst = 1'b1; id_regwrite = 1'b1;
        tick(); sample();
        check("add_a", 64'(alu_a), 64'd5);
        check("add_b", 64'(alu_b), 64'd7);
        check("add_op", 64'(alu_op), 64'd2);
        check("add_dst", 64'(ex_dst), 64'd3);

        // Funct decode and fixed aluop encodings
        for (int i = 0; i < 5; i++) begin
            id_funct = functs[i];
            tick(); sample();
            check("funct_op", 64'(alu_op), 64'(fops[i]));
        end
        id_aluop = 2'b01; tick(); sample(); check("sub_op", 64'(alu_op), 64'd6);
        id_aluop = 2'b11; tick(); sample(); check("or_op", 64'(alu_op), 64'd1);

        // Forwarding priority on operand A
        clear_id(); id_rs = 5'd4; id_rs_data = 32'h1234;
        tick(); stall = 1'b1;
        exmem_regwrite = 1'b1; exmem_rd = 5'd4; exmem_result = 32'hAAAA;
        memwb_regwrite = 1'b1; memwb_rd = 5'd4; memwb_result = 32'hBBBB;
        sample(); check("fwd_exmem", 64'(alu_a), 64'hAAAA);
        exmem_regwrite = 1'b0; #1 check_all(); check("fwd_memwb", 64'(alu_a), 64'hBBBB);
        stall = 1'b0; clear_id(); id_rs = 5'd0; id_rs_data = 32'h77;
        tick(); exmem_regwrite = 1'b1; exmem_rd = 5'd0; exmem_result = 32'hDEAD;
        sample(); check("fwd_zero", 64'(alu_a), 64'h77);

        // Store: immediate on B, forwarded rt on store data
        clear_id(); id_rt = 5'd6; id_rt_data = 32'h99; id_imm = 32'h10;
        id_alusrc = 1'b1; id_memwrite = 1'b1;
        tick(); exmem_regwrite = 1'b1; exmem_rd = 5'd6; exmem_result = 32'h55;
        sample();
        check("sw_b", 64'(alu_b), 64'h10);
        check("sw_store", 64'(ex_store_data), 64'h55);

        // Load-use: lw $8 in EX, dependent instruction in ID
        clear_id(); id_rt = 5'd8; id_alusrc = 1'b1; id_memread = 1'b1;
        id_regwrite = 1'b1; id_memtoreg = 1'b1;
        tick(); clear_id(); id_rs = 5'd8; id_rt = 5'd9; id_memwrite = 1'b1;
        sample(); check("lu_hazard", 64'(load_use_hazard), 64'd1);
        stall = 1'b1; flush = 1'b1;
        tick(); stall = 1'b0; flush = 1'b0;
        sample();
        check("lu_valid", 64'(ex_valid), 64'd0);
        check("lu_memwrite", 64'(ex_memwrite), 64'd0);
        check("lu_clear", 64'(load_use_hazard), 64'd0);

        // Stall hold with changing ID inputs
        rand_id(); id_valid = 1'b1; tick(); sample();
        held_a = alu_a; held_b = alu_b; held_dst = ex_dst;
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_id(); tick(); sample();
            check("hold_a", 64'(alu_a), 64'(held_a));
            check("hold_b", 64'(alu_b), 64'(held_b));
            check("hold_dst", 64'(ex_dst), 64'(held_dst));
        end
        stall = 1'b0; rand_id(); tick(); sample();

        // Randomized traffic with occasional async reset
        for (int n = 0; n < 400; n++) begin
            rand_id(); rand_fwd();
            stall = ($urandom_range(0, 4) == 0);
            flush = ($urandom_range(0, 7) == 0);
            tick(); sample();
            if ($urandom_range(0, 40) == 0) begin
                #1 rst_n = 1'b0; model_reset();
                #1 check_all();
                #1 rst_n = 1'b1;
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
